pwm_deadtime: RTL

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time insertion for CHANNELS complementary gate-drive pairs.
// Ports: clk_i/rst_i (sync, active-high), pwm_i raw PWM, enable_i per channel,
//        deadtime_i shared dead-time length, pwm_h_o/pwm_l_o gate drives.
// Optional macro PWM_DEADTIME_FAULT_EN adds fault_i, fault_clr_i, fault_o
// (latched fault shutdown of all channels).
// Latency: one cycle from a sampled pwm_i edge with deadtime_i=0; otherwise
// deadtime_i cycles of both-low followed by the new side.
module pwm_deadtime #(
  parameter int CHANNELS = 3,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] pwm_i,
  input  logic [CHANNELS-1:0] enable_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic                fault_i,
  input  logic                fault_clr_i,
  output logic                fault_o,
`endif
  output logic [CHANNELS-1:0] pwm_h_o,
  output logic [CHANNELS-1:0] pwm_l_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON_H = 2'd1,
    ON_L = 2'd2,
    DEAD = 2'd3
  } state_e;

  // Load value makes DEAD last exactly deadtime_i cycles: the exit decision
  // is taken in the cycle the counter reads zero.
  logic                dt_zero;
  logic [DT_WIDTH-1:0] dt_load;
  logic                force_idle;

  assign dt_zero = (deadtime_i == '0);
  assign dt_load = deadtime_i - 1'b1;

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_q, fault_d;

  // A fault present in the same cycle as a clear request keeps the latch set.
  always_comb begin
    fault_d = fault_q;
    if (fault_i) begin
      fault_d = 1'b1;
    end else if (fault_clr_i) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // The raw fault input is included so shutdown happens on the very next edge.
  assign force_idle = fault_i | fault_q;
  assign fault_o    = fault_q;
`else
  assign force_idle = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                side_h;

    assign side_h = pwm_i[g];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE, ON_H, ON_L: begin
          // Leave IDLE on enable, ON_H on pwm low, ON_L on pwm high.
          if ((state_q == IDLE) ||
              (state_q == ON_H && !side_h) ||
              (state_q == ON_L &&  side_h)) begin
            if (dt_zero) begin
              state_d = side_h ? ON_H : ON_L;
              cnt_d   = '0;
            end else begin
              state_d = DEAD;
              cnt_d   = dt_load;
            end
          end
        end
        DEAD: begin
          // pwm_i is ignored until expiry; the exit side follows pwm_i then.
          if (cnt_q == '0) begin
            state_d = side_h ? ON_H : ON_L;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (!enable_i[g] || force_idle) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Decoded purely from the state register, so h and l are mutually exclusive.
    assign pwm_h_o[g] = (state_q == ON_H);
    assign pwm_l_o[g] = (state_q == ON_L);
  end

endmodule
